// File: rtl/lpcm_rx_sink_if.sv
// Bus bundle for the LPCM receive sink: the serial link input and the
// parallel left/right pair output with its status flags.
interface lpcm_rx_sink_if #(
  parameter int SAMPLE_W = 24
);
  logic                bit_en;
  logic                ws;
  logic                sdata;
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_left;
  logic [SAMPLE_W-1:0] out_right;
  logic                frame_err;
  logic                overflow;

  modport master (
    output bit_en, ws, sdata, out_ready,
    input  out_valid, out_left, out_right, frame_err, overflow
  );

  modport slave (
    input  bit_en, ws, sdata, out_ready,
    output out_valid, out_left, out_right, frame_err, overflow
  );
endinterface

// File: rtl/lpcm_rx_sink.sv
// LPCM receive sink: deserializes a left-justified two-channel stream into
// left/right pairs, buffers them in a small FIFO and flags framing errors.
module lpcm_rx_sink #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  lpcm_rx_sink_if.slave bus
);
  localparam int CW = $clog2(SLOT_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_SAMPLE = CW'(SAMPLE_W);
  localparam logic [CW-1:0] C_SLOT   = CW'(SLOT_W);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  typedef enum logic [1:0] {S_HUNT, S_LEFT, S_RIGHT} state_t;

  state_t                r_state, w_state_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx, w_cnt_inc;
  logic                  r_prev_ws;
  logic [SAMPLE_W-1:0]   r_left_sh, w_left_sh_nx;
  logic [SAMPLE_W-1:0]   r_right_sh, w_right_sh_nx;
  logic [SAMPLE_W-1:0]   r_left_hold, w_left_hold_nx;
  logic [SAMPLE_W-1:0]   w_sd_ext, w_left_shift, w_right_shift;
  logic                  w_boundary, w_push, w_ferr_nx;
  logic [2*SAMPLE_W-1:0] w_push_data;
  logic                  r_frame_err, r_overflow;

  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic [SAMPLE_W-1:0]   r_mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0]   r_mem_r [FIFO_DEPTH];
  logic                  w_empty, w_full, w_pop, w_wr;

  assign w_sd_ext      = SAMPLE_W'(bus.sdata);
  assign w_left_shift  = (r_left_sh << 1) | w_sd_ext;
  assign w_right_shift = (r_right_sh << 1) | w_sd_ext;
  assign w_boundary    = (bus.ws != r_prev_ws);
  assign w_cnt_inc     = (r_cnt == C_SLOT) ? r_cnt : r_cnt + C_ONE;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_left_sh_nx   = r_left_sh;
    w_right_sh_nx  = r_right_sh;
    w_left_hold_nx = r_left_hold;
    w_push         = 1'b0;
    w_push_data    = {r_left_hold, r_right_sh};
    w_ferr_nx      = 1'b0;
    if (bus.bit_en) begin
      w_cnt_nx = w_cnt_inc;
      unique case (r_state)
        S_HUNT: begin
          if (w_boundary && !bus.ws) begin
            w_state_nx   = S_LEFT;
            w_left_sh_nx = w_sd_ext;
            w_cnt_nx     = C_ONE;
          end
        end
        S_LEFT: begin
          if (w_boundary) begin
            if (r_cnt >= C_SAMPLE) begin
              w_state_nx     = S_RIGHT;
              w_left_hold_nx = r_left_sh;
              w_right_sh_nx  = w_sd_ext;
              w_cnt_nx       = C_ONE;
              // A one-bit sample completes the right channel on its MSB.
              if (C_SAMPLE == C_ONE) begin
                w_push      = 1'b1;
                w_push_data = {r_left_sh, w_sd_ext};
              end
            end else begin
              w_ferr_nx  = 1'b1;
              w_state_nx = S_HUNT;
            end
          end else if (r_cnt == C_SLOT) begin
            w_ferr_nx  = 1'b1;
            w_state_nx = S_HUNT;
          end else if (r_cnt < C_SAMPLE) begin
            w_left_sh_nx = w_left_shift;
          end
        end
        S_RIGHT: begin
          if (w_boundary) begin
            // A short right slot is an error, but its ws edge still opens a left slot.
            w_ferr_nx    = (r_cnt < C_SAMPLE);
            w_state_nx   = S_LEFT;
            w_left_sh_nx = w_sd_ext;
            w_cnt_nx     = C_ONE;
          end else if (r_cnt == C_SLOT) begin
            w_ferr_nx  = 1'b1;
            w_state_nx = S_HUNT;
          end else if (r_cnt < C_SAMPLE) begin
            w_right_sh_nx = w_right_shift;
            if (w_cnt_inc == C_SAMPLE) begin
              w_push      = 1'b1;
              w_push_data = {r_left_hold, w_right_shift};
            end
          end
        end
        default: w_state_nx = S_HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HUNT;
      r_cnt       <= '0;
      r_prev_ws   <= 1'b0;
      r_left_sh   <= '0;
      r_right_sh  <= '0;
      r_left_hold <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_prev_ws   <= bus.bit_en ? bus.ws : r_prev_ws;
      r_left_sh   <= w_left_sh_nx;
      r_right_sh  <= w_right_sh_nx;
      r_left_hold <= w_left_hold_nx;
      r_frame_err <= w_ferr_nx;
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  // NOTE: pair storage is not reset; the outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_l[r_wr_ptr[AW-1:0]] <= w_push_data[2*SAMPLE_W-1:SAMPLE_W];
      r_mem_r[r_wr_ptr[AW-1:0]] <= w_push_data[SAMPLE_W-1:0];
    end
  end

  assign bus.out_valid = !w_empty;
  assign bus.out_left  = w_empty ? '0 : r_mem_l[r_rd_ptr[AW-1:0]];
  assign bus.out_right = w_empty ? '0 : r_mem_r[r_rd_ptr[AW-1:0]];
  assign bus.frame_err = r_frame_err;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_lpcm_rx_sink.sv
// Bench for lpcm_rx_sink: a slot-level model predicts pushes and framing
// errors per serial bit, a queue models the FIFO, outputs compared each cycle.
module tb_lpcm_rx_sink;
  localparam int SW    = 24;
  localparam int SLW   = 32;
  localparam int DEPTH = 4;
  localparam int MAXB  = 1024;

  typedef struct packed {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } pair_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  lpcm_rx_sink_if #(.SAMPLE_W(SW)) bus ();

  lpcm_rx_sink #(.SAMPLE_W(SW), .SLOT_W(SLW), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_err = 0;
  logic  st_ws[$];
  logic  st_sd[$];
  bit    ev_push[MAXB];
  bit    ev_err[MAXB];
  pair_t ev_data[MAXB];
  pair_t mq[$];
  pair_t rx_q[$];
  logic  exp_ferr = 1'b0;
  logic  exp_ovf = 1'b0;
  int    n_push = 0;
  int    n_ferr = 0;
  int    last_bit = -1;
  int    first_valid_bit = -1;
  bit    seen_valid = 1'b0;
  bit    chk_en = 1'b0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pair_t mk(input logic [SW-1:0] l, input logic [SW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    return p;
  endfunction

  // Slot of nbits serial bits: sample MSB first, padding bits set to 1.
  task automatic add_slot(input logic w, input logic [SW-1:0] val, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      st_ws.push_back(w);
      st_sd.push_back((b < SW) ? val[SW-1-b] : 1'b1);
    end
  endtask

  task automatic add_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    add_slot(1'b0, l, SLW);
    add_slot(1'b1, r, SLW);
  endtask

  function automatic logic [SW-1:0] slot_val(input int start);
    logic [SW-1:0] v = '0;
    for (int b = 0; b < SW; b++) v = (v << 1) | SW'(st_sd[start+b]);
    return v;
  endfunction

  // Split the stream into constant-ws runs and apply the slot rules per run.
  task automatic analyse();
    int rs[$];
    int rl[$];
    logic rw[$];
    int mode;
    bit has_next;
    logic [SW-1:0] lval;
    for (int i = 0; i < MAXB; i++) begin
      ev_push[i] = 1'b0;
      ev_err[i]  = 1'b0;
      ev_data[i] = '0;
    end
    for (int i = 0; i < st_ws.size(); i++) begin
      if (i == 0 || st_ws[i] != st_ws[i-1]) begin
        rs.push_back(i);
        rw.push_back(st_ws[i]);
        rl.push_back(1);
      end else begin
        rl[rl.size()-1]++;
      end
    end
    mode = 0;
    lval = '0;
    for (int r = 0; r < rs.size(); r++) begin
      has_next = (r + 1 < rs.size());
      if (mode == 0) begin
        if (!(rw[r] == 1'b0 && r > 0)) continue;
        mode = 1;
      end
      if (mode == 1) begin
        if (rl[r] > SLW) begin
          ev_err[rs[r]+SLW] = 1'b1;
          mode = 0;
        end else if (has_next) begin
          if (rl[r] >= SW) begin
            lval = slot_val(rs[r]);
            mode = 2;
          end else begin
            ev_err[rs[r+1]] = 1'b1;
            mode = 0;
          end
        end
      end else begin
        if (rl[r] >= SW) begin
          ev_push[rs[r]+SW-1] = 1'b1;
          ev_data[rs[r]+SW-1] = mk(lval, slot_val(rs[r]));
        end
        if (rl[r] > SLW) begin
          ev_err[rs[r]+SLW] = 1'b1;
          mode = 0;
        end else begin
          if (has_next && rl[r] < SW) ev_err[rs[r+1]] = 1'b1;
          mode = 1;
        end
      end
    end
  endtask

  task automatic model_update(input logic be, input int idx, input logic rdy);
    if (rdy && mq.size() != 0) mq.delete(0);
    exp_ferr = be && ev_err[idx];
    if (be && ev_push[idx]) begin
      n_push++;
      if (mq.size() < DEPTH) mq.push_back(ev_data[idx]);
      else exp_ovf = 1'b1;
    end
    if (be) last_bit = idx;
  endtask

  task automatic step(input logic be, input logic w, input logic sd, input logic rdy, input int idx);
    bus.bit_en    = be;
    bus.ws        = w;
    bus.sdata     = sd;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    model_update(be, idx, rdy);
  endtask

  task automatic run_stream(input int gap, input bit noise, input int rmode);
    analyse();
    for (int i = 0; i < st_ws.size(); i++) begin
      for (int g = 1; g < gap; g++)
        step(1'b0, noise ? 1'($urandom) : 1'b0, noise ? 1'($urandom) : 1'b0, rmode == 0, i);
      step(1'b1, st_ws[i], st_sd[i],
           (rmode == 0) || (rmode == 2 && ev_push[i] && n_push >= DEPTH), i);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic do_reset();
    bus.bit_en    = 1'b0;
    bus.ws        = 1'b0;
    bus.sdata     = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    mq.delete();
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_left", bus.out_left, '0);
    check("reset out_right", bus.out_right, '0);
    check("reset frame_err", bus.frame_err, 1'b0);
    check("reset overflow", bus.overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic new_scenario();
    do_reset();
    st_ws.delete();
    st_sd.delete();
    rx_q.delete();
    n_push = 0;
    n_ferr = 0;
    last_bit = -1;
    first_valid_bit = -1;
    seen_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", bus.out_valid, mq.size() != 0);
      check("frame_err", bus.frame_err, exp_ferr);
      check("overflow", bus.overflow, exp_ovf);
      if (mq.size() != 0) begin
        check("out_left", bus.out_left, mq[0].l);
        check("out_right", bus.out_right, mq[0].r);
      end
      if (bus.frame_err === 1'b1) n_ferr++;
      if (bus.out_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1'b1;
        first_valid_bit = last_bit;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
        rx_q.push_back(mk(bus.out_left, bus.out_right));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.bit_en    = 1'b0;
    bus.ws        = 1'b0;
    bus.sdata     = 1'b0;
    bus.out_ready = 1'b0;
    chk_en = 1'b1;

    // Single pair, continuous bit_en.
    new_scenario();
    add_slot(1'b1, '0, 4);
    add_pair(24'hABCDEF, 24'h123456);
    run_stream(1, 1'b0, 0);
    drain(4);
    check("s1 pairs", rx_q.size(), 1);
    check("s1 pair", rx_q[0], {24'hABCDEF, 24'h123456});
    check("s1 valid bit", first_valid_bit, 59);
    check("s1 ferr", n_ferr, 0);

    // Five pairs into a stalled four-deep FIFO.
    new_scenario();
    add_slot(1'b1, '0, 4);
    for (int n = 1; n <= 5; n++) add_pair(SW'(n), SW'(32'h100 + n));
    run_stream(1, 1'b0, 1);
    check("s2 overflow", bus.overflow, 1'b1);
    check("s2 valid", bus.out_valid, 1'b1);
    drain(8);
    check("s2 pairs", rx_q.size(), 4);
    check("s2 first", rx_q[0], {24'h000001, 24'h000101});
    check("s2 last", rx_q[3], {24'h000004, 24'h000104});

    // Short left slot, then a good pair.
    new_scenario();
    add_slot(1'b1, '0, 4);
    add_slot(1'b0, 24'hFFFF00, 16);
    add_slot(1'b1, 24'h123456, SLW);
    add_pair(24'h000001, 24'h000002);
    run_stream(1, 1'b0, 0);
    drain(4);
    check("s3 ferr", n_ferr, 1);
    check("s3 pairs", rx_q.size(), 1);
    check("s3 pair", rx_q[0], {24'h000001, 24'h000002});

    // Stream opens inside a long right slot.
    new_scenario();
    add_slot(1'b1, 24'h5A5A5A, 40);
    add_pair(24'h0A0B0C, 24'h0D0E0F);
    add_pair(24'h111111, 24'h222222);
    run_stream(1, 1'b0, 0);
    drain(4);
    check("s4 ferr", n_ferr, 0);
    check("s4 valid bit", first_valid_bit, 95);
    check("s4 pairs", rx_q.size(), 2);
    check("s4 second", rx_q[1], {24'h111111, 24'h222222});

    // Sparse bit_en with noise between enables.
    new_scenario();
    add_slot(1'b1, '0, 4);
    add_pair(24'hABCDEF, 24'h123456);
    run_stream(3, 1'b1, 0);
    drain(4);
    check("s5 pairs", rx_q.size(), 1);
    check("s5 pair", rx_q[0], {24'hABCDEF, 24'h123456});
    check("s5 valid bit", first_valid_bit, 59);
    check("s5 ferr", n_ferr, 0);

    // Reset in the middle of a right slot with a pair waiting.
    new_scenario();
    add_slot(1'b1, '0, 4);
    add_pair(24'h55AA55, 24'h0F0F0F);
    add_slot(1'b0, 24'hABCDEF, SLW);
    add_slot(1'b1, 24'h123456, 10);
    run_stream(1, 1'b0, 1);
    check("s6 held valid", bus.out_valid, 1'b1);
    check("s6 held left", bus.out_left, 24'h55AA55);
    new_scenario();
    add_slot(1'b1, '0, 4);
    add_pair(24'h777777, 24'h888888);
    run_stream(1, 1'b0, 0);
    drain(4);
    check("s6 pairs", rx_q.size(), 1);
    check("s6 pair", rx_q[0], {24'h777777, 24'h888888});

    // Left slot longer than SLOT_W.
    new_scenario();
    add_slot(1'b1, '0, 4);
    add_slot(1'b0, 24'h123456, 40);
    add_slot(1'b1, 24'h654321, SLW);
    add_pair(24'h000003, 24'h000004);
    run_stream(1, 1'b0, 0);
    drain(4);
    check("s7 ferr", n_ferr, 1);
    check("s7 pairs", rx_q.size(), 1);
    check("s7 pair", rx_q[0], {24'h000003, 24'h000004});

    // Short right slot whose ws edge starts the next left slot.
    new_scenario();
    add_slot(1'b1, '0, 4);
    add_slot(1'b0, 24'h0000AA, SLW);
    add_slot(1'b1, 24'h0000BB, 16);
    add_slot(1'b1, '0, 0);
    add_pair(24'h000003, 24'h000004);
    run_stream(1, 1'b0, 0);
    drain(4);
    check("s8 ferr", n_ferr, 1);
    check("s8 pairs", rx_q.size(), 1);
    check("s8 pair", rx_q[0], {24'h000003, 24'h000004});

    // Push into a full FIFO on the same cycle as a pop.
    new_scenario();
    add_slot(1'b1, '0, 4);
    for (int n = 1; n <= 5; n++) add_pair(SW'(32'h10 + n), SW'(32'h20 + n));
    run_stream(1, 1'b0, 2);
    check("s9 overflow", bus.overflow, 1'b0);
    drain(8);
    check("s9 pairs", rx_q.size(), 5);
    check("s9 first", rx_q[0], {24'h000011, 24'h000021});
    check("s9 last", rx_q[4], {24'h000015, 24'h000025});

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/lpcm_rx_sink.md
Name: lpcm_rx_sink

Overview:
- Receive-side endpoint of the LPCM serial link: the sink that the LPCM driver transmits into.
- Deserializes a left-justified two-channel serial stream (word select + serial data, qualified by a bit enable) into parallel left/right sample pairs.
- Buffers the pairs in a small FIFO and presents them on a valid/ready interface.
- Flags framing errors and overflow, for use by scoreboard/monitor logic.

Parameters:
- SAMPLE_W, 24, bits per captured sample (MSB-first); 1..SLOT_W.
- SLOT_W, 32, bit periods per channel slot; bits beyond SAMPLE_W are ignored.
- FIFO_DEPTH, 4, number of buffered left/right pairs; power of 2, >=2.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- bit_en  in  1  qualifies one serial bit period; ws and sdata are sampled only when high.
- ws  in  1  word select: 0 = left slot, 1 = right slot.
- sdata  in  1  serial sample data, MSB first.
- out_valid  out  1  FIFO head holds a pair.
- out_ready  in  1  consumer accepts the head pair.
- out_left  out  SAMPLE_W  left sample of the head pair.
- out_right  out  SAMPLE_W  right sample of the head pair.
- frame_err  out  1  one-cycle pulse on a framing violation.
- overflow  out  1  sticky; set when a completed pair is dropped; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_left=0, out_right=0, frame_err=0, overflow=0.
  - FIFO emptied, bit counter=0, prev_ws=0, state=HUNT.
- Slot boundary: a bit_en cycle where ws differs from prev_ws. prev_ws updates on every bit_en cycle. The bit sampled on the boundary cycle is the MSB of the new slot (left-justified, no 1-bit delay).
- States:
  - HUNT: wait for a boundary with ws=0, then go to LEFT and capture that bit as the MSB. A boundary with ws=1 is ignored, so a pair always starts with left.
  - LEFT: shift sdata into the left shift register while the counter < SAMPLE_W. The counter increments on each bit_en cycle.
    - Boundary with ws=1: if the counter >= SAMPLE_W, latch the left holding register, go to RIGHT and capture the MSB.
    - Boundary with ws=1 and counter < SAMPLE_W: frame_err pulse, discard, go to HUNT.
  - RIGHT: shift as in LEFT. The cycle that samples the SAMPLE_W-th right bit pushes {left_hold, right_shift} into the FIFO.
    - Boundary with ws=0 after a complete right slot: go to LEFT and capture the MSB.
    - Boundary with ws=0 and counter < SAMPLE_W: frame_err pulse, no push; the ws=0 edge starts a new LEFT slot directly.
  - In LEFT or RIGHT, if the counter reaches SLOT_W with no boundary: frame_err pulse, go to HUNT. Any pair already pushed is kept.
- Counter: cleared on every boundary; saturates at SLOT_W.
- FIFO:
  - A pushed pair drives out_valid high on the next clk edge (push-to-valid latency = 1 cycle).
  - A pop occurs on a cycle with out_valid & out_ready.
  - out_left/out_right are stable while out_valid is high and out_ready is low.
  - A push into a full FIFO drops the new pair and sets overflow.
  - Push and pop in the same cycle while full: the push is accepted and overflow is not set.
  - Order is strictly preserved.
- frame_err is registered: it asserts on the cycle after the violating bit_en cycle.
- bit_en low: no state, counter or shift change. The FIFO still pops.
- Mid-operation reset: any partial slot is discarded and everything returns to reset values immediately; the next pair requires a fresh ws 1->0 boundary from HUNT.

Test Plan:
- bit_en=1 every cycle, SLOT_W=32, left=0xABCDEF, right=0x123456, out_ready=1 -> one pair out_left=0xABCDEF, out_right=0x123456. out_valid rises 1 cycle after the 24th right bit. No frame_err.
- out_ready=0, 5 consecutive pairs (L=n, R=0x100+n, n=1..5) -> out_valid=1, overflow=1 after pair 5. Draining yields pairs 1..4 in order; pair 5 is absent.
- Left slot cut to 16 bits (ws 0->1 early) -> one frame_err pulse, no pair. The next well-formed pair 0x000001/0x000002 is received correctly.
- Stream starts with ws=1 for 40 bits, then normal pairs -> nothing output and no frame_err until the first ws 1->0 boundary. Subsequent pairs are correct.
- bit_en high once every 3 cycles, with noise toggles on ws/sdata between enables -> identical data to the first scenario; the noise is ignored.
- reset asserted at bit 10 of a right slot, then released -> outputs return to 0 asynchronously, the FIFO is empty, and the partial pair is never output. Pairs after the next ws 1->0 boundary are received correctly.
